// File: rtl/bta_operand_loader.sv
// Serial-to-parallel operand loader for the 8-operand binary tree adder.
// Collects eight words plus carry-in, holds them for ADD_LAT cycles and flags the result cycle.
module bta_operand_loader #(
  parameter int W       = 64,
  parameter int ADD_LAT = 1,
  parameter int CW      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_cin,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [W-1:0] op_c,
  output logic [W-1:0] op_d,
  output logic [W-1:0] op_e,
  output logic [W-1:0] op_f,
  output logic [W-1:0] op_g,
  output logic [W-1:0] op_h,
  output logic         c0,
  output logic         ops_valid,
  output logic         sum_valid,
  output logic [3:0]   fill_cnt,
  output logic [0:0]   state_dbg
);

  // Stream handshake: a word moves on a rising edge where in_valid && in_ready.
  // in_valid may rise/fall freely; in_ready depends only on state and reset.
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(ADD_LAT - 1);

  logic [0:0]    state_q, state_d;
  logic [3:0]    fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  ops_q [8];
  logic [W-1:0]  ops_d [8];
  logic          c0_q, c0_d;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    c0_d    = c0_q;
    if (abort) begin
      // Flush the set but keep operand contents; ops_valid gates them.
      state_d = S_FILL;
      fill_d  = 4'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (in_valid) begin
            ops_d[fill_q[2:0]] = in_data;
            if (fill_q == 4'd0) c0_d = in_cin;
            fill_d = fill_q + 4'd1;
            if (fill_q == 4'd7) begin
              state_d = S_HOLD;
              cnt_d   = '0;
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_FILL;
            fill_d  = 4'd0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_FILL;
          fill_d  = 4'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      fill_q  <= 4'd0;
      cnt_q   <= '0;
      c0_q    <= 1'b0;
      for (int i = 0; i < 8; i++) ops_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      c0_q    <= c0_d;
      ops_q   <= ops_d;
    end
  end

  assign in_ready  = rst_n && (state_q == S_FILL);
  assign ops_valid = (state_q == S_HOLD);
  assign sum_valid = (state_q == S_HOLD) && (cnt_q == CNT_LAST);
  assign fill_cnt  = fill_q;
  assign state_dbg = state_q;
  assign c0        = c0_q;
  assign op_a      = ops_q[0];
  assign op_b      = ops_q[1];
  assign op_c      = ops_q[2];
  assign op_d      = ops_q[3];
  assign op_e      = ops_q[4];
  assign op_f      = ops_q[5];
  assign op_g      = ops_q[6];
  assign op_h      = ops_q[7];

endmodule

// File: doc/bta_operand_loader.md
Name: bta_operand_loader

Overview:
- Upstream stage of the 8-operand binary tree adder (BTA_RCA).
- Accepts operands serially over a valid/ready stream and fills slots A..H. Slot 0 also captures the carry-in.
- Presents all eight operands plus C0 in parallel, held stable for the adder's latency.
- Pulses sum_valid in the cycle the adder's sum/carry outputs are valid, then re-arms for the next set.

Parameters:
- W, 64, operand width; must match the adder's operand width.
- ADD_LAT, 1, cycles from operand presentation until the adder's sum is valid; legal range 1..15. Use 1 for a purely combinational adder.
- CW, 4, hold-counter width; must satisfy 2^CW > ADD_LAT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- abort  input  1  synchronous flush of a partial or in-flight operand set.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept an operand this cycle.
- in_data  input  W  operand word; the Nth accepted word goes to slot N.
- in_cin  input  1  carry-in; sampled only on the slot-0 transfer.
- op_a .. op_h  output  W each  operand slots 0..7, registered; eight separate ports.
- c0  output  1  registered carry-in to the adder.
- ops_valid  output  1  high while the full operand set is presented (HOLD state).
- sum_valid  output  1  one-cycle pulse marking the cycle the adder's result is valid.
- fill_cnt  output  4  number of operands accepted in the current set, 0..8.

Behaviour:
- States: FILL, HOLD. Two-state FSM, registered.
- Reset (rst_n=0 at a clk edge):
  - state=FILL, fill_cnt=0, hold counter=0.
  - op_a..op_h=0, c0=0, ops_valid=0, sum_valid=0.
  - in_ready is forced to 0 combinationally while rst_n=0.
  - Reset overrides abort and any transfer in the same cycle.
- in_ready = rst_n && (state==FILL). A transfer occurs when in_valid && in_ready at a rising edge.
- FILL:
  - Each transfer writes in_data into the slot indexed by fill_cnt (0 → op_a, ..., 7 → op_h), then fill_cnt increments.
  - On the fill_cnt=0 transfer, c0 <= in_cin.
  - Slots not yet rewritten keep their previous-set values. Only ops_valid qualifies the operand outputs.
  - in_valid=0 stalls indefinitely with no state change.
- FILL → HOLD: at the edge that accepts the 8th word.
  - Same edge: op_h is loaded, fill_cnt=8, ops_valid=1, hold counter=0.
- HOLD:
  - in_ready=0. op_a..op_h and c0 are frozen.
  - The hold counter increments every cycle.
  - sum_valid=1 in the HOLD cycle where counter==ADD_LAT-1, and 0 in every other cycle.
- HOLD → FILL: at the edge following the sum_valid cycle.
  - Same edge: ops_valid=0, fill_cnt=0, counter=0.
  - in_ready is 1 in the first FILL cycle, so back-to-back sets cost ADD_LAT dead cycles.
- Timing example: if ops_valid first rises in cycle t, sum_valid is high in cycle t+ADD_LAT-1 and in_ready returns in cycle t+ADD_LAT. With ADD_LAT=1, sum_valid coincides with the first ops_valid cycle.
- abort (rst_n=1):
  - Next edge: state=FILL, fill_cnt=0, counter=0, ops_valid=0, sum_valid=0. A transfer in the abort cycle is discarded.
  - Operand registers are not cleared.
  - In HOLD, abort in the same cycle as sum_valid still suppresses nothing already driven, but the set ends at that edge.
- Widths: no arithmetic on data, pass-through only. fill_cnt never exceeds 8. The counter never exceeds ADD_LAT-1.

Test Plan:
- Reset then fill: hold rst_n=0 for 3 cycles with in_valid=1 → in_ready=0 and all outputs 0. Release rst_n, stream words 1..8 with in_cin=1 → op_a=1 .. op_h=8, c0=1, ops_valid rises the cycle after the 8th transfer, fill_cnt=8.
- Latency: ADD_LAT=3 with the first operand set from the existing BTA_RCA_32 bench (A=0x5E3A_593A_480E_39DA .. H=0xF5C7_5846_1239_53AF) → sum_valid high exactly in the 3rd ops_valid cycle. Operands stay stable for 3 cycles, and in_ready=1 the next cycle.
- Stalls: toggle in_valid 1,0,0,1,... across 8 words → only valid cycles advance fill_cnt, and slot order is preserved.
- Back-to-back: in_valid held at 1 for 16 words, ADD_LAT=1 → the second set lands in op_a..op_h exactly 1 dead cycle after the first set's sum_valid. Two sum_valid pulses total.
- Abort at fill_cnt=5 → fill_cnt=0 next cycle, no ops_valid. The next 8 words fill from op_a. Abort during HOLD → ops_valid=0 next cycle and no sum_valid afterwards.
- Reset mid-HOLD with rst_n=0 and abort=1 together → all outputs return to reset values at the next edge. in_ready=0 during reset and 1 after release.
